fofb_link_packet_assembler: RTL and testbench
=============================================

// Module: fofb_link_packet_assembler
// PURPOSE
// Downstream of the FOFB read-links mux. Consumes the merged byte stream
// (TUSER=1 marks the first byte of a packet), packs bytes MSB-first into
// 32-bit words and emits fixed-length packets of PACKET_WORDS words with TLAST.
// Runt/stalled packets are terminated with an error-flagged word; status counters go to the register bank.
// PARAMETERS
// PACKET_WORDS  8   32-bit words per packet (>=1)
// TIMEOUT       64  idle cycles mid-packet before forced flush; 0 disables
// PORTS
// sysClk           in   1   single clock for all logic
// sysReset         in   1   synchronous, active-high reset
// S_AXIS_TVALID    in   1   input byte valid
// S_AXIS_TREADY    out  1   input byte accepted when TVALID&TREADY
// S_AXIS_TDATA     in   8   input byte
// S_AXIS_TUSER     in   1   1 = first byte of packet (SOP)
// M_AXIS_TVALID    out  1   output word valid
// M_AXIS_TREADY    in   1   downstream ready
// M_AXIS_TDATA     out  32  packed word, first byte in [31:24]
// M_AXIS_TLAST     out  1   last word of packet (normal or aborted)
// M_AXIS_TUSER     out  1   1 = aborted packet (runt/timeout); valid with TLAST
// packetCount      out  16  complete packets emitted, wraps
// runtCount        out  16  aborted packets (runt + timeout), wraps
// dropCount        out  16  non-SOP bytes discarded in IDLE, wraps
// BEHAVIOUR
// - Reset: all outputs 0 (S_AXIS_TREADY may be 1 only from cycle after reset release), state IDLE,
//   byte/word indices 0; partial packet discarded silently (no flush word, no count).
// - outFree = !M_AXIS_TVALID | M_AXIS_TREADY. Output register holds word until TVALID&TREADY.
// - S_AXIS_TREADY = !sysReset_q & (outFree | (state==COLLECT & byteIdx!=3 & !S_AXIS_TUSER)
//   | state==IDLE & !S_AXIS_TUSER) -- bytes needing output reg only accepted when outFree.
// - IDLE: accepted byte with TUSER=0 -> dropped, dropCount++. TUSER=1 -> byte to [31:24],
//   byteIdx=1, wordIdx=0, -> COLLECT.
// - COLLECT, accepted byte TUSER=0: shift into word; at byteIdx==3 load output register next
//   cycle (TVALID=1, 1-cycle latency), byteIdx=0, wordIdx++. If wordIdx==PACKET_WORDS-1:
//   TLAST=1, TUSER=0, packetCount++, -> IDLE.
// - COLLECT, accepted byte TUSER=1 (runt): output loaded with partial word zero-padded
//   (all-zero if byteIdx==0), TLAST=1, TUSER=1, runtCount++; same cycle new byte starts
//   fresh packet (byteIdx=1, wordIdx=0), stay COLLECT.
// - Timeout: idle counter clears on every accepted byte and on entry to COLLECT; counts
//   cycles in COLLECT without accepted byte. At count==TIMEOUT and outFree: flush
//   zero-padded partial word with TLAST=1,TUSER=1, runtCount++, -> IDLE. If !outFree,
//   flush waits (counter holds) until outFree. Arriving byte same cycle as timeout: byte wins.
// - Counters increment in cycle the output word is loaded (not consumed); 0xFFFF -> 0x0000.
// - Output TDATA/TLAST/TUSER stable while TVALID & !TREADY (AXIS rule).
// - Throughput: one byte/cycle sustained when M_AXIS_TREADY=1.
// TESTING (bench: PACKET_WORDS=2, TIMEOUT=16)
// 1 Reset: after sysReset deasserts, all outputs 0, counters 0, no TVALID.
// 2 Bytes 11..18 (SOP on 11), TREADY=1 -> words 0x11121314 then 0x15161718 TLAST=1
//   TUSER=0, packetCount=1, word 2 valid 1 cycle after byte 18.
// 3 Bytes 0xAA,0xBB (no SOP) then good packet -> dropCount=2, packet intact.
// 4 SOP 01,02,03 then SOP 21..28 -> 0x01020300 TLAST=1 TUSER=1, runtCount=1, then
//   0x21222324, 0x25262728 TLAST.
// 5 SOP 01..05 then silence 16 cycles -> 0x01020304, 0x05000000 TLAST=1 TUSER=1, state IDLE.
// 6 Random M_AXIS_TREADY backpressure over 1000 packets with random runts:
//   no data loss/duplication, TDATA stable while stalled, counters match scoreboard.

Source files
------------

// File: rtl/fofb_link_packet_assembler.sv
// Packs the merged FOFB read-link byte stream MSB-first into 32-bit words and emits
// fixed-length packets with TLAST; runt or stalled packets end with an error-flagged word.
module fofb_link_packet_assembler #(
    parameter int PACKET_WORDS = 8,
    parameter int TIMEOUT      = 64
) (
    input  logic        sysClk,
    input  logic        sysReset,
    input  logic        S_AXIS_TVALID,
    output logic        S_AXIS_TREADY,
    input  logic [7:0]  S_AXIS_TDATA,
    input  logic        S_AXIS_TUSER,
    output logic        M_AXIS_TVALID,
    input  logic        M_AXIS_TREADY,
    output logic [31:0] M_AXIS_TDATA,
    output logic        M_AXIS_TLAST,
    output logic        M_AXIS_TUSER,
    output logic [15:0] packetCount,
    output logic [15:0] runtCount,
    output logic [15:0] dropCount
);

    localparam int WW = (PACKET_WORDS > 1) ? $clog2(PACKET_WORDS) : 1;
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WW-1:0] LAST_WORD = WW'(PACKET_WORDS - 1);
    localparam logic [CW-1:0] TO_LIMIT  = CW'(TIMEOUT);

    typedef enum logic {IDLE, COLLECT} state_t;

    state_t        r_state;
    logic [1:0]    r_byteIdx;
    logic [WW-1:0] r_wordIdx;
    logic [31:0]   r_word;
    logic [CW-1:0] r_idleCnt;
    logic          r_rstQ;
    logic          r_tvalid;
    logic [31:0]   r_tdata;
    logic          r_tlast;
    logic          r_tuser;
    logic [15:0]   r_pktCnt;
    logic [15:0]   r_runtCnt;
    logic [15:0]   r_dropCnt;

    logic          w_outFree;
    logic          w_ready;
    logic          w_acc;
    logic          w_timeout;
    logic [31:0]   w_word;

    assign w_outFree = !r_tvalid | M_AXIS_TREADY;
    // Bytes that only land in the shift word can be taken even while the output is stalled.
    assign w_ready   = !sysReset & !r_rstQ &
                       (w_outFree |
                        (r_state == COLLECT && r_byteIdx != 2'd3 && !S_AXIS_TUSER) |
                        (r_state == IDLE && !S_AXIS_TUSER));
    assign w_acc     = S_AXIS_TVALID & w_ready;
    assign w_timeout = (TIMEOUT != 0) && (r_idleCnt == TO_LIMIT);

    always_comb begin
        w_word = r_word;
        case (r_byteIdx)
            2'd0:    w_word[31:24] = S_AXIS_TDATA;
            2'd1:    w_word[23:16] = S_AXIS_TDATA;
            2'd2:    w_word[15:8]  = S_AXIS_TDATA;
            default: w_word[7:0]   = S_AXIS_TDATA;
        endcase
    end

    always_ff @(posedge sysClk) begin
        if (sysReset) begin
            r_state   <= IDLE;
            r_byteIdx <= '0;
            r_wordIdx <= '0;
            r_word    <= '0;
            r_idleCnt <= '0;
            r_rstQ    <= 1'b1;
            r_tvalid  <= 1'b0;
            r_tdata   <= '0;
            r_tlast   <= 1'b0;
            r_tuser   <= 1'b0;
            r_pktCnt  <= '0;
            r_runtCnt <= '0;
            r_dropCnt <= '0;
        end else begin
            r_rstQ <= 1'b0;
            if (r_tvalid && M_AXIS_TREADY)
                r_tvalid <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (w_acc) begin
                        if (S_AXIS_TUSER) begin
                            r_word    <= {S_AXIS_TDATA, 24'h0};
                            r_byteIdx <= 2'd1;
                            r_wordIdx <= '0;
                            r_idleCnt <= '0;
                            r_state   <= COLLECT;
                        end else begin
                            r_dropCnt <= r_dropCnt + 16'd1;
                        end
                    end
                end
                COLLECT: begin
                    if (w_acc) begin
                        r_idleCnt <= '0;
                        if (S_AXIS_TUSER) begin
                            // Runt: flush what we have, and the SOP byte opens the next packet.
                            r_tvalid  <= 1'b1;
                            r_tdata   <= r_word;
                            r_tlast   <= 1'b1;
                            r_tuser   <= 1'b1;
                            r_runtCnt <= r_runtCnt + 16'd1;
                            r_word    <= {S_AXIS_TDATA, 24'h0};
                            r_byteIdx <= 2'd1;
                            r_wordIdx <= '0;
                        end else if (r_byteIdx == 2'd3) begin
                            r_tvalid  <= 1'b1;
                            r_tdata   <= w_word;
                            r_tlast   <= (r_wordIdx == LAST_WORD);
                            r_tuser   <= 1'b0;
                            r_word    <= '0;
                            r_byteIdx <= 2'd0;
                            if (r_wordIdx == LAST_WORD) begin
                                r_pktCnt <= r_pktCnt + 16'd1;
                                r_state  <= IDLE;
                            end else begin
                                r_wordIdx <= r_wordIdx + 1'b1;
                            end
                        end else begin
                            r_word    <= w_word;
                            r_byteIdx <= r_byteIdx + 2'd1;
                        end
                    end else if (w_timeout) begin
                        // Counter holds at the limit until the output register frees up.
                        if (w_outFree) begin
                            r_tvalid  <= 1'b1;
                            r_tdata   <= r_word;
                            r_tlast   <= 1'b1;
                            r_tuser   <= 1'b1;
                            r_runtCnt <= r_runtCnt + 16'd1;
                            r_word    <= '0;
                            r_byteIdx <= 2'd0;
                            r_wordIdx <= '0;
                            r_state   <= IDLE;
                        end
                    end else begin
                        r_idleCnt <= r_idleCnt + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign S_AXIS_TREADY = w_ready;
    assign M_AXIS_TVALID = r_tvalid;
    assign M_AXIS_TDATA  = r_tdata;
    assign M_AXIS_TLAST  = r_tlast;
    assign M_AXIS_TUSER  = r_tuser;
    assign packetCount   = r_pktCnt;
    assign runtCount     = r_runtCnt;
    assign dropCount     = r_dropCnt;

endmodule

// File: tb/tb_fofb_link_packet_assembler.sv
// Scoreboard bench for fofb_link_packet_assembler (PACKET_WORDS=2, TIMEOUT=16).
module tb_fofb_link_packet_assembler;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        s_tvalid = 1'b0;
    logic        s_tready;
    logic [7:0]  s_tdata = 8'h00;
    logic        s_tuser = 1'b0;
    logic        m_tvalid;
    logic        m_tready = 1'b1;
    logic [31:0] m_tdata;
    logic        m_tlast;
    logic        m_tuser;
    logic [15:0] pkt_cnt, runt_cnt, drop_cnt;

    int errors = 0;
    int checks = 0;
    logic [33:0] exp_q[$];
    bit rand_ready = 1'b0;

    int exp_pkt = 0, exp_runt = 0, exp_drop = 0;

    // byte-level reference of the packing rules, used for the random run
    bit         m_collect = 1'b0;
    int         m_bidx = 0, m_widx = 0;
    logic [31:0] m_word = '0;

    fofb_link_packet_assembler #(.PACKET_WORDS(2), .TIMEOUT(16)) dut (
        .sysClk(clk), .sysReset(rst),
        .S_AXIS_TVALID(s_tvalid), .S_AXIS_TREADY(s_tready),
        .S_AXIS_TDATA(s_tdata), .S_AXIS_TUSER(s_tuser),
        .M_AXIS_TVALID(m_tvalid), .M_AXIS_TREADY(m_tready),
        .M_AXIS_TDATA(m_tdata), .M_AXIS_TLAST(m_tlast), .M_AXIS_TUSER(m_tuser),
        .packetCount(pkt_cnt), .runtCount(runt_cnt), .dropCount(drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] d, input logic l, input logic u);
        exp_q.push_back({d, l, u});
    endtask

    task automatic send(input logic [7:0] b, input logic sop);
        int n;
        n = 0;
        s_tvalid = 1'b1;
        s_tdata  = b;
        s_tuser  = sop;
        forever begin
            @(negedge clk);
            if (s_tready) break;
            n++;
            if (n > 500) begin
                checks++; errors++;
                $display("FAIL send_timeout: byte %h never accepted", b);
                break;
            end
        end
        @(posedge clk); #1;
        s_tvalid = 1'b0;
        s_tuser  = 1'b0;
    endtask

    task automatic model_send(input logic [7:0] b, input logic sop);
        if (!m_collect) begin
            if (sop) begin
                m_word = {b, 24'h0}; m_bidx = 1; m_widx = 0; m_collect = 1'b1;
            end else begin
                exp_drop++;
            end
        end else if (sop) begin
            push(m_word, 1'b1, 1'b1);
            exp_runt++;
            m_word = {b, 24'h0}; m_bidx = 1; m_widx = 0;
        end else begin
            m_word = m_word | ({24'h0, b} << (8 * (3 - m_bidx)));
            if (m_bidx == 3) begin
                push(m_word, m_widx == 1, 1'b0);
                m_word = '0; m_bidx = 0;
                if (m_widx == 1) begin
                    exp_pkt++; m_collect = 1'b0;
                end else begin
                    m_widx++;
                end
            end else begin
                m_bidx++;
            end
        end
        send(b, sop);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 || m_tvalid) begin
            @(posedge clk); #1;
            n++;
            if (n > 300) begin
                checks++; errors++;
                $display("FAIL drain_timeout: %0d words still expected", exp_q.size());
                break;
            end
        end
    endtask

    task automatic check_counters(input string tag);
        check({tag, "_packetCount"}, {16'h0, pkt_cnt}, exp_pkt[31:0]);
        check({tag, "_runtCount"}, {16'h0, runt_cnt}, exp_runt[31:0]);
        check({tag, "_dropCount"}, {16'h0, drop_cnt}, exp_drop[31:0]);
    endtask

    // output monitor: pops the scoreboard on each handshake, checks hold during stalls
    initial begin
        logic        prev_stall;
        logic [33:0] prev_out;
        logic [33:0] e;
        prev_stall = 1'b0;
        prev_out   = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("stall_hold_valid", {31'h0, m_tvalid}, 32'h1);
                    check("stall_hold_word", {m_tdata}, prev_out[33:2]);
                    check("stall_hold_flags", {30'h0, m_tlast, m_tuser}, {30'h0, prev_out[1:0]});
                end
                if (m_tvalid && m_tready) begin
                    if (exp_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_word: got %h last=%b user=%b, none expected",
                                 m_tdata, m_tlast, m_tuser);
                    end else begin
                        e = exp_q.pop_front();
                        check("word_data", m_tdata, e[33:2]);
                        check("word_flags", {30'h0, m_tlast, m_tuser}, {30'h0, e[1:0]});
                    end
                end
                prev_stall = m_tvalid && !m_tready;
                prev_out   = {m_tdata, m_tlast, m_tuser};
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk); #1;
            if (rand_ready) m_tready = ($urandom_range(0, 9) < 7);
            else            m_tready = 1'b1;
        end
    end

    initial begin
        int n;
        int len;
        logic [7:0] b;

        repeat (4) @(posedge clk);
        @(negedge clk);
        check("reset_s_tready", {31'h0, s_tready}, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rel_m_tvalid", {31'h0, m_tvalid}, 32'h0);
        check("rel_s_tready", {31'h0, s_tready}, 32'h0);
        check("rel_outputs", {m_tdata}, 32'h0);
        check("rel_flags", {30'h0, m_tlast, m_tuser}, 32'h0);
        check_counters("reset");
        @(posedge clk); #1;

        // normal packet
        push(32'h11121314, 1'b0, 1'b0);
        push(32'h15161718, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) send(8'h11 + 8'(i), i == 0);
        check("latency_valid", {31'h0, m_tvalid}, 32'h1);
        check("latency_word", m_tdata, 32'h15161718);
        exp_pkt = 1;
        drain();
        check_counters("t2");

        // non-SOP bytes in IDLE are dropped
        send(8'hAA, 1'b0);
        send(8'hBB, 1'b0);
        push(32'h31323334, 1'b0, 1'b0);
        push(32'h35363738, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) send(8'h31 + 8'(i), i == 0);
        exp_pkt = 2; exp_drop = 2;
        drain();
        check_counters("t3");

        // runt then good packet
        push(32'h01020300, 1'b1, 1'b1);
        push(32'h21222324, 1'b0, 1'b0);
        push(32'h25262728, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) send(8'h01 + 8'(i), i == 0);
        for (int i = 0; i < 8; i++) send(8'h21 + 8'(i), i == 0);
        exp_pkt = 3; exp_runt = 1;
        drain();
        check_counters("t4");

        // timeout flush
        push(32'h01020304, 1'b0, 1'b0);
        push(32'h05000000, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) send(8'h01 + 8'(i), i == 0);
        n = 0;
        while (!(m_tvalid && m_tlast) && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        check("timeout_cycles", n, 32'd17);
        exp_runt = 2;
        drain();
        send(8'h77, 1'b0);
        exp_drop = 3;
        @(posedge clk); #1;
        check_counters("t5");

        // random backpressure with random runts and drops
        rand_ready = 1'b1;
        for (int p = 0; p < 1000; p++) begin
            len = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 8;
            for (int i = 0; i < len; i++) begin
                b = 8'($urandom);
                model_send(b, i == 0);
            end
            if (len == 8 && $urandom_range(0, 7) == 0) begin
                b = 8'($urandom);
                model_send(b, 1'b0);
            end
        end
        for (int i = 0; i < 8; i++) begin
            b = 8'($urandom);
            model_send(b, i == 0);
        end
        drain();
        rand_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_counters("t6");
        check("t6_queue_empty", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
